// File: rtl/nn_pkg.sv
// nn_pkg: shared constants and types for the hidden-layer datapath.
//   W_WIDTH      - weight width in bits (unsigned 1.7 fixed point)
//   W_PER_NEURON - weights per hidden neuron (one per neuron input bit)
//   NEURON_OUT_W - width of a hidden neuron's output sum
//   wl_state_t   - weight_loader FSM state encoding
package nn_pkg;

  localparam int W_WIDTH      = 8;
  localparam int W_PER_NEURON = 4;
  localparam int NEURON_OUT_W = 10;

  // WL_CHECK is only reachable when WEIGHT_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [1:0] {
    WL_IDLE   = 2'd0,
    WL_LOAD   = 2'd1,
    WL_CHECK  = 2'd2,
    WL_COMMIT = 2'd3
  } wl_state_t;

endpackage

// File: rtl/weight_loader_if.sv
// weight_loader_if: byte-wide weight stream into weight_loader.
//   start_i - one-cycle pulse that begins or restarts a load frame
//   data_i  - weight or checksum byte
//   valid_i - data_i is valid
//   ready_o - loader accepts a byte this cycle
// master: the stream source.  slave: the weight_loader.
interface weight_loader_if
  import nn_pkg::*;
();

  logic               start_i;
  logic [W_WIDTH-1:0] data_i;
  logic               valid_i;
  logic               ready_o;

  modport master (output start_i, output data_i, output valid_i, input ready_o);
  modport slave  (input start_i, input data_i, input valid_i, output ready_o);

endinterface

// File: rtl/weight_bank.sv
// weight_bank: double-buffered weight storage.
//   clk_i, rst_i - clock and synchronous active-high reset
//   wr_en_i      - write wr_data_i into shadow[wr_idx_i]
//   wr_idx_i     - shadow write index
//   wr_data_i    - shadow write data
//   commit_i     - copy the whole shadow bank into the active bank
//   active_o     - active bank, entry k at bits [k*W_WIDTH +: W_WIDTH]
module weight_bank
  import nn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [IDX_W-1:0]         wr_idx_i,
  input  logic [W_WIDTH-1:0]       wr_data_i,
  input  logic                     commit_i,
  output logic [DEPTH*W_WIDTH-1:0] active_o
);

  logic [W_WIDTH-1:0]       shadow_q [DEPTH];
  logic [W_WIDTH-1:0]       shadow_d [DEPTH];
  logic [DEPTH*W_WIDTH-1:0] active_q;
  logic [DEPTH*W_WIDTH-1:0] active_d;

  // The active bank only ever changes as a whole, so consumers never see a
  // mix of old and new weights.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en_i) begin
      shadow_d[wr_idx_i] = wr_data_i;
    end
    if (commit_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        active_d[k*W_WIDTH +: W_WIDTH] = shadow_q[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        shadow_q[k] <= '0;
      end
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/weight_loader.sv
// weight_loader: loads NUM_NEURONS*W_PER_NEURON weight bytes from a
// valid/ready stream into a shadow bank and commits them atomically to the
// active bank driven onto weights_o.
//   clk_i, rst_i    - clock and synchronous active-high reset
//   s_if            - weight stream (start_i, data_i, valid_i, ready_o)
//   weights_o       - active bank, byte k at bits [k*8 +: 8]
//   weights_valid_o - active bank holds a committed set (sticky)
//   busy_o          - a frame is in progress
//   done_o          - one-cycle pulse on a successful commit
//   err_o           - sticky checksum failure, cleared by start or reset
// Build option: WEIGHT_LOADER_CHECKSUM_EN adds a trailing checksum byte
// (sum of the weight bytes mod 256) that must match before commit.
module weight_loader
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  weight_loader_if.slave                            s_if,
  output logic [NUM_NEURONS*W_PER_NEURON*W_WIDTH-1:0] weights_o,
  output logic                                      weights_valid_o,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      err_o
);

  localparam int N     = NUM_NEURONS * W_PER_NEURON;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  wl_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wvalid_q, wvalid_d;
  logic             accept;
  logic             shadow_we;
  logic             commit;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [W_WIDTH-1:0] sum_q, sum_d;
  logic               err_q, err_d;
`endif

  // ready_q is the registered ready, so a transfer is simply valid && ready_q.
  assign accept = s_if.valid_i && ready_q;

  // Next-state logic.  A start pulse in LOAD/CHECK wins over a byte offered in
  // the same cycle: the frame restarts and that byte is not stored.  The
  // counter holds at LAST instead of wrapping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wvalid_d  = wvalid_q;
    done_d    = 1'b0;
    shadow_we = 1'b0;
    commit    = 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      WL_IDLE: begin
        if (s_if.start_i) begin
          state_d = WL_LOAD;
          cnt_d   = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      WL_LOAD: begin
        if (s_if.start_i) begin
          cnt_d = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          sum_d = '0;
          err_d = 1'b0;
`endif
        end else if (accept) begin
          shadow_we = 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          sum_d     = sum_q + s_if.data_i;
`endif
          if (cnt_q == LAST) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            state_d = WL_CHECK;
`else
            state_d = WL_COMMIT;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      WL_CHECK: begin
        if (s_if.start_i) begin
          state_d = WL_LOAD;
          cnt_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
        end else if (accept) begin
          if (s_if.data_i == sum_q) begin
            state_d = WL_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = WL_IDLE;
          end
        end
      end
`endif
      WL_COMMIT: begin
        commit   = 1'b1;
        wvalid_d = 1'b1;
        done_d   = 1'b1;
        state_d  = WL_IDLE;
      end
      default: begin
        state_d = WL_IDLE;
      end
    endcase
    ready_d = (state_d == WL_LOAD) || (state_d == WL_CHECK);
    busy_d  = (state_d != WL_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= WL_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wvalid_q <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wvalid_q <= wvalid_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
      err_q    <= err_d;
`endif
    end
  end

  weight_bank #(
    .DEPTH (N),
    .IDX_W (CNT_W)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (shadow_we),
    .wr_idx_i  (cnt_q),
    .wr_data_i (s_if.data_i),
    .commit_i  (commit),
    .active_o  (weights_o)
  );

  assign s_if.ready_o    = ready_q;
  assign weights_valid_o = wvalid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: self-checking bench for weight_loader.
// Works with or without WEIGHT_LOADER_CHECKSUM_EN defined.
module tb_weight_loader;
  import nn_pkg::*;

  localparam int NN = 4;
  localparam int N  = NN * W_PER_NEURON;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef logic [7:0] frame_t [N];

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    bit         toggle;
    logic [7:0] ckDelta;
    string      tag;
    logic [7:0] expFirst;
    logic [7:0] expLast;
    bit         expCommit;
    bit         expErr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  weight_loader_if wlIf ();

  logic [N*W_WIDTH-1:0] weights;
  logic                 weightsValid;
  logic                 busy;
  logic                 done;
  logic                 err;

  weight_loader #(.NUM_NEURONS(NN)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .s_if            (wlIf),
    .weights_o       (weights),
    .weights_valid_o (weightsValid),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err)
  );

  int tests     = 0;
  int failures  = 0;
  int doneCount = 0;
  bit readyDrop;

  // Reference model: what the active bank should hold after each frame.
  logic [7:0] refBank [N];
  bit         refValid;
  bit         refErr;

  // Counts done pulses shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) doneCount++;
  end

  function automatic logic [N*W_WIDTH-1:0] packRef();
    logic [N*W_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*8 +: 8] = refBank[k];
    return v;
  endfunction

  // Behavioural hidden neuron: sum of weights whose input bit is set.
  function automatic logic [NEURON_OUT_W-1:0] neuronOut(input logic [N*W_WIDTH-1:0] w,
                                                         input int n, input logic [3:0] x);
    int acc;
    acc = 0;
    for (int i = 0; i < W_PER_NEURON; i++)
      if (x[i]) acc += int'(w[(n*W_PER_NEURON+i)*8 +: 8]);
    return NEURON_OUT_W'(acc);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic startPulse();
    wlIf.start_i = 1'b1;
    @(negedge clk);
    wlIf.start_i = 1'b0;
    checkOutput("readyAfterStart", wlIf.ready_o, 1'b1);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gap);
    int waitCnt;
    waitCnt = 0;
    if (gap) begin
      wlIf.valid_i = 1'b0;
      @(negedge clk);
      if (wlIf.ready_o !== 1'b1) readyDrop = 1'b1;
    end
    wlIf.data_i  = b;
    wlIf.valid_i = 1'b1;
    if (wlIf.ready_o !== 1'b1) readyDrop = 1'b1;
    while (wlIf.ready_o !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 50) begin
      tests++;
      failures++;
      $display("[TB] FAIL handshakeTimeout: ready_o low for %0d cycles, expected high", waitCnt);
    end
    @(negedge clk);
  endtask

  // Runs one complete frame and checks commit timing against the model.
  task automatic applyStimulus(input frame_t bytes, input logic [7:0] ckDelta,
                               input bit toggle, input string tag);
    logic [7:0]           sum;
    logic [7:0]           ck;
    bit                   good;
    int                   doneBefore;
    logic [N*W_WIDTH-1:0] oldW;
    sum = 8'h00;
    for (int k = 0; k < N; k++) sum = sum + bytes[k];
    ck   = sum ^ ckDelta;
    good = !CK_EN || (ck == sum);
    oldW = packRef();
    doneBefore = doneCount;
    readyDrop  = 1'b0;
    startPulse();
    refErr = 1'b0;
    for (int k = 0; k < N; k++) sendByte(bytes[k], toggle);
    if (CK_EN) sendByte(ck, toggle);
    wlIf.valid_i = 1'b0;
    checkOutput({tag, "_readyHeld"}, readyDrop, 1'b0);
    checkOutput({tag, "_doneEarly"}, done, 1'b0);
    checkOutput({tag, "_holdWeights"}, weights, oldW);
    if (good) begin
      checkOutput({tag, "_busyCommit"}, busy, 1'b1);
      for (int k = 0; k < N; k++) refBank[k] = bytes[k];
      refValid = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_donePulse"}, done, 1'b1);
      checkOutput({tag, "_newWeights"}, weights, packRef());
      @(negedge clk);
      checkOutput({tag, "_doneOneCycle"}, done, 1'b0);
    end else begin
      refErr = 1'b1;
      checkOutput({tag, "_busyAfterErr"}, busy, 1'b0);
      @(negedge clk);
    end
    checkOutput({tag, "_doneCount"}, doneCount - doneBefore, good ? 1 : 0);
    checkOutput({tag, "_err"}, err, refErr);
    checkOutput({tag, "_wvalid"}, weightsValid, refValid);
    checkOutput({tag, "_weights"}, weights, packRef());
    checkOutput({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, wlIf.ready_o, 1'b0);
    checkOutput({tag, "_weights"}, weights, '0);
    checkOutput({tag, "_wvalid"}, weightsValid, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_err"}, err, 1'b0);
  endtask

  function automatic vec_t mkVec(input logic [7:0] base, input logic [7:0] step, input bit toggle,
                                 input logic [7:0] ckDelta, input string tag, input logic [7:0] expFirst,
                                 input logic [7:0] expLast, input bit expCommit, input bit expErr);
    vec_t v;
    v.base = base; v.step = step; v.toggle = toggle; v.ckDelta = ckDelta; v.tag = tag;
    v.expFirst = expFirst; v.expLast = expLast; v.expCommit = expCommit; v.expErr = expErr;
    return v;
  endfunction

  initial begin
    vec_t   vecs [4];
    frame_t fr;
    int     doneBefore;
    logic [N*W_WIDTH-1:0] savedW;

    // Frame 0x11 x16 sums to 0x10, so delta 0x10 sends checksum 0x00.
    vecs[0] = mkVec(8'h01, 8'h01, 1'b0, 8'h00, "seq",       8'h01, 8'h10, 1'b1, 1'b0);
    vecs[1] = mkVec(8'h01, 8'h01, 1'b1, 8'h00, "seqToggle", 8'h01, 8'h10, 1'b1, 1'b0);
    vecs[2] = mkVec(8'h40, 8'h00, 1'b0, 8'h00, "all40",     8'h40, 8'h40, 1'b1, 1'b0);
    vecs[3] = mkVec(8'h11, 8'h00, 1'b0, 8'h10, "badCk",
                    CK_EN ? 8'h40 : 8'h11, CK_EN ? 8'h40 : 8'h11, !CK_EN, CK_EN);

    for (int k = 0; k < N; k++) refBank[k] = 8'h00;
    refValid = 1'b0;
    refErr   = 1'b0;
    wlIf.start_i = 1'b0;
    wlIf.valid_i = 1'b0;
    wlIf.data_i  = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkResetState("reset");

    // Bytes offered while idle must be ignored.
    wlIf.valid_i = 1'b1;
    wlIf.data_i  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idleNoReady", wlIf.ready_o, 1'b0);
    end
    wlIf.valid_i = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < N; k++) fr[k] = vecs[v].base + 8'(k) * vecs[v].step;
      doneBefore = doneCount;
      applyStimulus(fr, vecs[v].ckDelta, vecs[v].toggle, vecs[v].tag);
      checkOutput({vecs[v].tag, "_first"}, weights[7:0], vecs[v].expFirst);
      checkOutput({vecs[v].tag, "_last"}, weights[127:120], vecs[v].expLast);
      checkOutput({vecs[v].tag, "_commit"}, doneCount - doneBefore, vecs[v].expCommit);
      checkOutput({vecs[v].tag, "_expErr"}, err, vecs[v].expErr);
    end

    // Restart after 8 bytes of a 0xFF frame, then a full 0x20 frame.
    savedW = weights;
    doneBefore = doneCount;
    startPulse();
    for (int k = 0; k < 8; k++) sendByte(8'hFF, 1'b0);
    wlIf.valid_i = 1'b0;
    checkOutput("partialHold", weights, savedW);
    for (int k = 0; k < N; k++) fr[k] = 8'h20;
    applyStimulus(fr, 8'h00, 1'b0, "restart");
    checkOutput("restartAll20", weights, {N{8'h20}});
    checkOutput("restartOneDone", doneCount - doneBefore, 1);

    // One-cycle reset in the middle of LOAD after a commit.
    startPulse();
    for (int k = 0; k < 3; k++) sendByte(8'h55, 1'b0);
    wlIf.valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) refBank[k] = 8'h00;
    refValid = 1'b0;
    refErr   = 1'b0;
    checkResetState("midReset");

    // Weights of 0x7F with all inputs high give 4*0x7F per neuron.
    for (int k = 0; k < N; k++) fr[k] = 8'h7F;
    applyStimulus(fr, 8'h00, 1'b1, "neuron7F");
    for (int n = 0; n < NN; n++)
      checkOutput($sformatf("neuron%0d", n), neuronOut(weights, n, 4'b1111), 10'h1FC);

    // Random frames against the model.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) fr[k] = 8'($urandom);
      applyStimulus(fr, ($urandom % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                    1'($urandom % 2), $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
